// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point adder: exception codes,
// per-operand classification struct and the canonical NaN pattern.
package fp_pkg;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_POS  = 2'b01;
  localparam logic [1:0] EXC_NEG  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  typedef struct packed {
    logic sign;
    logic is_inf;
    logic is_nan;
  } fp_unpk_t;

  // All-ones word of width w (w <= 64); callers slice the low w bits.
  function automatic logic [63:0] canonical_nan(input int w);
    canonical_nan = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) canonical_nan[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/fp_add_lzc.sv
// Leading-zero counter, purely combinational; returns W when the input is zero.
module fp_add_lzc #(
  parameter int W  = 14,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// 3-stage IEEE-style adder (align / add / normalise-round-pack), 3-cycle latency, one global
// stall: in_ready = !out_valid || out_ready. FP_ADD_SUBNORM_EN enables subnormal support.
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   sum,
  output logic [1:0]             exceptions
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int X  = MAN_W + 4;
  localparam int CW = $clog2(X + 1);
  localparam logic [63:0]      NAN64 = canonical_nan(W);
  localparam logic [EXP_W-1:0] EMAX  = '1;

  logic adv;
  logic v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
  logic s1_sign_q, s1_sub_q, s1_nan_q, s1_inf_q, s1_isgn_q;
  logic s1_sign_d, s1_sub_d, s1_nan_d, s1_inf_d, s1_isgn_d;
  logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic [X-1:0]     s1_big_q, s1_big_d, s1_small_q, s1_small_d;
  logic s2_sign_q, s2_sub_q, s2_nan_q, s2_inf_q, s2_isgn_q;
  logic s2_sign_d, s2_sub_d, s2_nan_d, s2_inf_d, s2_isgn_d;
  logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
  logic [X:0]       s2_mag_q, s2_mag_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [1:0]       exc_q, exc_d;

  assign adv        = !v3_q || out_ready;
  assign in_ready   = adv;
  assign out_valid  = v3_q;
  assign sum        = sum_q;
  assign exceptions = exc_q;
  assign v1_d       = in_valid;
  assign v2_d       = v1_q;
  assign v3_d       = v2_q;

  function automatic void unpack(input logic [W-1:0] v, output fp_unpk_t u,
                                 output logic [EXP_W-1:0] x, output logic [MAN_W:0] m);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e        = v[W-2:MAN_W];
    f        = v[MAN_W-1:0];
    u.sign   = v[W-1];
    u.is_inf = (e == EMAX) && (f == '0);
    u.is_nan = (e == EMAX) && (f != '0);
`ifdef FP_ADD_SUBNORM_EN
    x = (e == '0) ? EXP_W'(1) : e;
    m = {e != '0, f};
`else
    x = e;
    m = (e == '0) ? '0 : {1'b1, f};
`endif
  endfunction

  // S1: classify, order by magnitude, align the smaller operand with sticky collapse
  fp_unpk_t         ua, ub;
  logic [EXP_W-1:0] xa, xb;
  logic [MAN_W:0]   ma, mb, m_small;
  logic             a_big;
  logic [31:0]      shamt;
  logic [2*X-1:0]   shw;

  always_comb begin
    unpack(in_a, ua, xa, ma);
    unpack(in_b, ub, xb, mb);
    a_big      = {xa, ma} >= {xb, mb};
    s1_sign_d  = a_big ? ua.sign : ub.sign;
    s1_exp_d   = a_big ? xa : xb;
    s1_big_d   = {(a_big ? ma : mb), 3'b000};
    m_small    = a_big ? mb : ma;
    shamt      = 32'(a_big ? (xa - xb) : (xb - xa));
    if (shamt > 32'(X)) shamt = 32'(X);
    shw        = {m_small, 3'b000, {X{1'b0}}} >> shamt;
    s1_small_d = shw[2*X-1:X] | {{(X-1){1'b0}}, |shw[X-1:0]};
    s1_sub_d   = ua.sign ^ ub.sign;
    s1_nan_d   = ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && s1_sub_d);
    s1_inf_d   = ua.is_inf || ub.is_inf;
    s1_isgn_d  = ua.is_inf ? ua.sign : ub.sign;
  end

  // S2: magnitude add/subtract; big >= small so the difference never goes negative
  always_comb begin
    s2_mag_d  = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_small_q})
                         : ({1'b0, s1_big_q} + {1'b0, s1_small_q});
    s2_sign_d = s1_sign_q;
    s2_exp_d  = s1_exp_q;
    s2_sub_d  = s1_sub_q;
    s2_nan_d  = s1_nan_q;
    s2_inf_d  = s1_inf_q;
    s2_isgn_d = s1_isgn_q;
  end

  // S3: normalise, round to nearest even, pack and resolve specials
  logic [CW-1:0]    lz_cnt;
  logic [31:0]      e32, lz32, en, ef;
  logic [X-1:0]     n;
  logic [MAN_W+1:0] mr;
  logic [MAN_W-1:0] frac;
  logic             zero_res, flush, rnd_up;

  fp_add_lzc #(.W(X), .CW(CW)) u_lzc (
    .din (s2_mag_q[X-1:0]),
    .cnt (lz_cnt)
  );

  always_comb begin
    e32      = 32'(s2_exp_q);
    lz32     = 32'(lz_cnt);
    zero_res = 1'b0;
    flush    = 1'b0;
    n        = '0;
    en       = e32;
    if (s2_mag_q == '0) begin
      zero_res = 1'b1;
    end else if (s2_mag_q[X]) begin
      n  = {s2_mag_q[X:2], s2_mag_q[1] | s2_mag_q[0]};
      en = e32 + 32'd1;
    end else if (lz32 >= e32) begin
`ifdef FP_ADD_SUBNORM_EN
      n  = s2_mag_q[X-1:0] << (e32 - 32'd1);
      en = 32'd1;
`else
      flush = 1'b1;
`endif
    end else begin
      n  = s2_mag_q[X-1:0] << lz32;
      en = e32 - lz32;
    end
    rnd_up = n[2] & (n[1] | n[0] | n[3]);
    mr     = {1'b0, n[X-1:3]} + (MAN_W+2)'(rnd_up);
    if (mr[MAN_W+1]) begin
      frac = mr[MAN_W:1];
      ef   = en + 32'd1;
    end else begin
      frac = mr[MAN_W-1:0];
      ef   = mr[MAN_W] ? en : 32'd0;
    end
    sum_d = {s2_sign_q, ef[EXP_W-1:0], frac};
    exc_d = EXC_NONE;
    if (s2_nan_q) begin
      sum_d = NAN64[W-1:0];
      exc_d = EXC_NAN;
    end else if (s2_inf_q) begin
      sum_d = {s2_isgn_q, EMAX, {MAN_W{1'b0}}};
      exc_d = s2_isgn_q ? EXC_NEG : EXC_POS;
    end else if (zero_res) begin
      sum_d = {s2_sign_q & ~s2_sub_q, {(W-1){1'b0}}};
    end else if (flush) begin
      sum_d = {s2_sign_q, {(W-1){1'b0}}};
    end else if (ef >= 32'(EMAX)) begin
      sum_d = {s2_sign_q, EMAX, {MAN_W{1'b0}}};
      exc_d = s2_sign_q ? EXC_NEG : EXC_POS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
      s1_sign_q <= 1'b0; s1_sub_q <= 1'b0; s1_nan_q <= 1'b0; s1_inf_q <= 1'b0; s1_isgn_q <= 1'b0;
      s1_exp_q <= '0; s1_big_q <= '0; s1_small_q <= '0;
      s2_sign_q <= 1'b0; s2_sub_q <= 1'b0; s2_nan_q <= 1'b0; s2_inf_q <= 1'b0; s2_isgn_q <= 1'b0;
      s2_exp_q <= '0; s2_mag_q <= '0;
      sum_q <= '0; exc_q <= EXC_NONE;
    end else if (adv) begin
      v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d;
      s1_sign_q <= s1_sign_d; s1_sub_q <= s1_sub_d; s1_nan_q <= s1_nan_d;
      s1_inf_q <= s1_inf_d; s1_isgn_q <= s1_isgn_d;
      s1_exp_q <= s1_exp_d; s1_big_q <= s1_big_d; s1_small_q <= s1_small_d;
      s2_sign_q <= s2_sign_d; s2_sub_q <= s2_sub_d; s2_nan_q <= s2_nan_d;
      s2_inf_q <= s2_inf_d; s2_isgn_q <= s2_isgn_d;
      s2_exp_q <= s2_exp_d; s2_mag_q <= s2_mag_d;
      sum_q <= sum_d; exc_q <= exc_d;
    end
  end

endmodule
